rcu_rst_filter: RTL and testbench

- Reset-conditioning stage directly upstream of the rcu.
- Synchronises and debounces the raw external reset pad, merges watchdog and software reset requests, and stretches the result into one clean, glitch-free active-low system reset (rst_n_o, feeding rcu ext_rst_n_i).
- Records a sticky reset-cause vector for boot firmware.
- Runs on the always-on hfosc clock; its own reset comes from the power-on-reset cell.

---
 rtl/rcu_pkg.sv | 16 +
 rtl/rcu_sync.sv | 23 ++
 rtl/rcu_rst_filter.sv | 149 ++++++++++++++
 tb/tb_rcu_rst_filter.sv | 159 +++++++++++++++
 4 files changed

// File: rtl/rcu_pkg.sv
// Shared types and cause-bit indices for the reset-conditioning front end of the rcu.
package rcu_pkg;

  typedef enum logic [1:0] {
    HOLD     = 2'd0,
    RUN      = 2'd1,
    DEBOUNCE = 2'd2
  } rst_state_e;

  localparam int CAUSE_POR = 0;
  localparam int CAUSE_EXT = 1;
  localparam int CAUSE_WDT = 2;
  localparam int CAUSE_SW  = 3;
  localparam int CAUSE_W   = 4;

endpackage

// File: rtl/rcu_sync.sv
// N-stage synchroniser for an asynchronous input; all stages preset to RST_VAL under reset.
module rcu_sync #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] ff;

  // NOTE: sequential state uses non-blocking assignments so every stage samples its
  // neighbour's pre-edge value; blocking here would collapse the chain into one flop.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) ff <= {STAGES{RST_VAL}};
    else       ff <= {ff[STAGES-2:0], d};
  end

  assign q = ff[STAGES-1];

endmodule

// File: rtl/rcu_rst_filter.sv
// Debounces/synchronises reset sources and stretches them into one clean active-low reset.
// Optional software reset source enabled by defining RCU_RST_SW_EN.
module rcu_rst_filter
  import rcu_pkg::*;
#(
  parameter int SYNC_STAGES  = 2,
  parameter int DEBOUNCE_CYC = 16,
  parameter int STRETCH_CYC  = 64
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       ext_rst_n_i,
  input  logic       wdt_rst_n_i,
  input  logic       sw_rst_i,
  input  logic       cause_clr_i,
  output logic       rst_n_o,
  output logic [3:0] rst_cause_o,
  output logic       busy_o
);

  localparam int MAX_CYC   = (DEBOUNCE_CYC > STRETCH_CYC) ? DEBOUNCE_CYC : STRETCH_CYC;
  localparam int CNT_WIDTH = $clog2(MAX_CYC);
  localparam logic [CNT_WIDTH-1:0] DB_LAST = CNT_WIDTH'(DEBOUNCE_CYC - 1);
  localparam logic [CNT_WIDTH-1:0] ST_LAST = CNT_WIDTH'(STRETCH_CYC - 1);

  logic ext_s;
  logic wdt_s;
  logic sw_req;
  logic src_any;

  rst_state_e           state_q, state_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 rst_n_q, rst_n_d;
  logic [CAUSE_W-1:0]   cause_q, cause_d, cause_set;

  rcu_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_ext (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .d     (ext_rst_n_i),
    .q     (ext_s)
  );

  rcu_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_wdt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .d     (wdt_rst_n_i),
    .q     (wdt_s)
  );

`ifdef RCU_RST_SW_EN
  assign sw_req = sw_rst_i;
`else
  // Port stays on the interface so both builds share one netlist boundary.
  logic unused_sw;
  assign unused_sw = sw_rst_i;
  assign sw_req    = 1'b0;
`endif

  assign src_any = !wdt_s || sw_req;

  // NOTE: every signal written here gets a default first, so no path can leave one
  // unassigned and infer a latch.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rst_n_d   = rst_n_q;
    cause_set = '0;

    unique case (state_q)
      HOLD: begin
        rst_n_d = 1'b0;
        if (src_any || !ext_s) begin
          cnt_d                = '0;
          cause_set[CAUSE_WDT] = !wdt_s;
          cause_set[CAUSE_SW]  = sw_req;
          cause_set[CAUSE_EXT] = !ext_s;
        end else if (cnt_q == ST_LAST) begin
          state_d = RUN;
          rst_n_d = 1'b1;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      RUN: begin
        rst_n_d = 1'b1;
        if (src_any) begin
          state_d              = HOLD;
          rst_n_d              = 1'b0;
          cnt_d                = '0;
          cause_set[CAUSE_WDT] = !wdt_s;
          cause_set[CAUSE_SW]  = sw_req;
        end else if (!ext_s) begin
          state_d = DEBOUNCE;
          cnt_d   = '0;
        end
      end

      DEBOUNCE: begin
        if (src_any) begin
          state_d              = HOLD;
          rst_n_d              = 1'b0;
          cnt_d                = '0;
          cause_set[CAUSE_WDT] = !wdt_s;
          cause_set[CAUSE_SW]  = sw_req;
        end else if (ext_s) begin
          state_d = RUN;
          cnt_d   = '0;
        end else if (cnt_q == DB_LAST) begin
          state_d              = HOLD;
          rst_n_d              = 1'b0;
          cnt_d                = '0;
          cause_set[CAUSE_EXT] = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      default: begin
        state_d = HOLD;
        rst_n_d = 1'b0;
        cnt_d   = '0;
      end
    endcase

    // A source firing in the same cycle as a clear keeps its bit.
    cause_d = (cause_q & ~{CAUSE_W{cause_clr_i}}) | cause_set;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= HOLD;
      cnt_q   <= '0;
      rst_n_q <= 1'b0;
      cause_q <= CAUSE_W'(1) << CAUSE_POR;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rst_n_q <= rst_n_d;
      cause_q <= cause_d;
    end
  end

  assign rst_n_o     = rst_n_q;
  assign rst_cause_o = cause_q;
  assign busy_o      = (state_q != RUN);

endmodule

// File: tb/tb_rcu_rst_filter.sv
// Directed self-checking bench for rcu_rst_filter at default parameters (2/16/64).
module tb_rcu_rst_filter;

  logic       clk_i = 1'b0;
  logic       rst_i;
  logic       ext_rst_n_i;
  logic       wdt_rst_n_i;
  logic       sw_rst_i;
  logic       cause_clr_i;
  logic       rst_n_o;
  logic [3:0] rst_cause_o;
  logic       busy_o;

  int checks   = 0;
  int failures = 0;

  rcu_rst_filter dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .ext_rst_n_i (ext_rst_n_i),
    .wdt_rst_n_i (wdt_rst_n_i),
    .sw_rst_i    (sw_rst_i),
    .cause_clr_i (cause_clr_i),
    .rst_n_o     (rst_n_o),
    .rst_cause_o (rst_cause_o),
    .busy_o      (busy_o)
  );

  always #5 clk_i = ~clk_i;

  // Outputs are sampled 1 time unit after each rising edge; inputs change there too.
  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk_i);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  initial begin
    rst_i       = 1'b1;
    ext_rst_n_i = 1'b1;
    wdt_rst_n_i = 1'b1;
    sw_rst_i    = 1'b0;
    cause_clr_i = 1'b0;
    tick(3);
    check("por_rst_n", {3'b0, rst_n_o}, 4'b0000);
    check("por_busy",  {3'b0, busy_o},  4'b0001);
    check("por_cause", rst_cause_o,     4'b0001);

    // Release: rst_n_o rises on the 64th edge.
    rst_i = 1'b0;
    tick(63);
    check("rel_63_low",  {3'b0, rst_n_o}, 4'b0000);
    tick(1);
    check("rel_64_high", {3'b0, rst_n_o}, 4'b0001);
    check("rel_busy",    {3'b0, busy_o},  4'b0000);
    check("rel_cause",   rst_cause_o,     4'b0001);

    // Short ext glitch (10 cycles) is rejected.
    ext_rst_n_i = 1'b0;
    tick(10);
    check("glitch_rst_n", {3'b0, rst_n_o}, 4'b0001);
    check("glitch_busy",  {3'b0, busy_o},  4'b0001);
    ext_rst_n_i = 1'b1;
    tick(3);
    check("glitch_run",   {3'b0, busy_o},  4'b0000);
    check("glitch_cause", rst_cause_o,     4'b0001);

    // Long ext low: falls on edge 19, release 66 edges after pad rises.
    ext_rst_n_i = 1'b0;
    tick(18);
    check("ext_18_high", {3'b0, rst_n_o}, 4'b0001);
    tick(1);
    check("ext_19_low",  {3'b0, rst_n_o}, 4'b0000);
    check("ext_busy",    {3'b0, busy_o},  4'b0001);
    tick(11);
    ext_rst_n_i = 1'b1;
    tick(65);
    check("ext_rel_65_low",  {3'b0, rst_n_o}, 4'b0000);
    tick(1);
    check("ext_rel_66_high", {3'b0, rst_n_o}, 4'b0001);
    check("ext_cause",       rst_cause_o,     4'b0011);

    // One-cycle wdt pulse: low on edge 3, held for 64 cycles.
    wdt_rst_n_i = 1'b0;
    tick(1);
    wdt_rst_n_i = 1'b1;
    tick(1);
    check("wdt_2_high", {3'b0, rst_n_o}, 4'b0001);
    tick(1);
    check("wdt_3_low",  {3'b0, rst_n_o}, 4'b0000);
    check("wdt_cause",  rst_cause_o,     4'b0111);
    tick(63);
    check("wdt_66_low",  {3'b0, rst_n_o}, 4'b0000);
    tick(1);
    check("wdt_67_high", {3'b0, rst_n_o}, 4'b0001);
    cause_clr_i = 1'b1;
    tick(1);
    cause_clr_i = 1'b0;
    check("clr_cause", rst_cause_o, 4'b0000);

    // Software reset pulse while in DEBOUNCE.
    ext_rst_n_i = 1'b0;
    tick(5);
    check("sw_in_debounce", {3'b0, busy_o}, 4'b0001);
    sw_rst_i = 1'b1;
    tick(1);
    sw_rst_i    = 1'b0;
    ext_rst_n_i = 1'b1;
`ifdef RCU_RST_SW_EN
    check("sw_rst_n", {3'b0, rst_n_o}, 4'b0000);
    check("sw_cause", rst_cause_o,     4'b1000);
`else
    check("sw_rst_n", {3'b0, rst_n_o}, 4'b0001);
    check("sw_cause", rst_cause_o,     4'b0000);
`endif
    tick(66);
    check("sw_after_rst_n", {3'b0, rst_n_o}, 4'b0001);
    check("sw_after_busy",  {3'b0, busy_o},  4'b0000);

    // Enter HOLD via ext, add wdt, then POR mid-HOLD.
    ext_rst_n_i = 1'b0;
    tick(19);
    check("mid_ext_low", {3'b0, rst_n_o}, 4'b0000);
    wdt_rst_n_i = 1'b0;
    tick(3);
`ifdef RCU_RST_SW_EN
    check("mid_cause", rst_cause_o, 4'b1110);
`else
    check("mid_cause", rst_cause_o, 4'b0110);
`endif
    rst_i = 1'b1;
    #1;
    check("mid_por_cause", rst_cause_o,     4'b0001);
    check("mid_por_rst_n", {3'b0, rst_n_o}, 4'b0000);
    check("mid_por_busy",  {3'b0, busy_o},  4'b0001);
    ext_rst_n_i = 1'b1;
    wdt_rst_n_i = 1'b1;
    tick(3);
    rst_i = 1'b0;
    tick(63);
    check("mid_rel_63_low",  {3'b0, rst_n_o}, 4'b0000);
    tick(1);
    check("mid_rel_64_high", {3'b0, rst_n_o}, 4'b0001);
    check("mid_rel_cause",   rst_cause_o,     4'b0001);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
